// File: rtl/pe_row_feeder_if.sv
// Byte stream into pe_row_feeder: valid/ready handshake, transfer = in_valid_i & in_ready_o.
// The master modport is the producer side, the slave modport is the feeder side.
interface pe_row_feeder_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;

    modport master (output in_data_i, output in_valid_i, input in_ready_o);
    modport slave  (input in_data_i, input in_valid_i, output in_ready_o);
endinterface

// File: rtl/pe_row_feeder.sv
// Sequencer feeding one 1-D convolution PE: loads a KERNEL-tap filter, then slides a window over one row.
// Optional zero padding (same-size output) is enabled by defining FEEDER_ZERO_PAD_EN.
module pe_row_feeder #(
    parameter int DATA_W  = 8,
    parameter int KERNEL  = 3,
    parameter int ROW_LEN = 8
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                cfg_load_i,
    input  logic                row_start_i,
    pe_row_feeder_if.slave      stream_if,
    output logic [DATA_W-1:0]   filter_o,
    output logic [DATA_W-1:0]   ifmap_o,
    output logic                read_new_filter_val_o,
    output logic                read_new_ifmap_val_o,
    output logic                start_conv_o,
    input  logic                psum_valid_i,
    output logic                busy_o,
    output logic                row_done_o
);

    localparam int TAP_W = $clog2(KERNEL + 1);
    localparam int WIN_W = $clog2(ROW_LEN + 1);
`ifdef FEEDER_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
    localparam int NWIN   = ROW_LEN;
`else
    localparam bit PAD_EN = 1'b0;
    localparam int NWIN   = ROW_LEN - KERNEL + 1;
`endif
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL - 1);
    localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(NWIN - 1);
    localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD_FILT, PRIME, START, WAIT, SHIFT} state_e;

    state_e             state_q;
    logic [TAP_W-1:0]   tapCnt_q;
    logic [WIN_W-1:0]   winCnt_q;
    logic               filtLoaded_q;
    logic [DATA_W-1:0]  filter_q;
    logic [DATA_W-1:0]  ifmap_q;
    logic               readFilt_q;
    logic               readIfmap_q;
    logic               startConv_q;
    logic               rowDone_q;

    logic               padSlot;
    logic               inReady;
    logic               xfer;
    logic               ifmapEmit;
    logic [DATA_W-1:0]  ifmap_d;

    // Pad slots inject a zero sample in place of a stream byte: first PRIME tap and last SHIFT.
    assign padSlot   = PAD_EN && (((state_q == PRIME) && (tapCnt_q == '0)) ||
                                  ((state_q == SHIFT) && (winCnt_q == LAST_WIN)));
    assign inReady   = (state_q == LOAD_FILT) ||
                       (((state_q == PRIME) || (state_q == SHIFT)) && !padSlot);
    assign xfer      = stream_if.in_valid_i && inReady;
    assign ifmapEmit = ((state_q == PRIME) || (state_q == SHIFT)) && (xfer || padSlot);
    assign ifmap_d   = padSlot ? '0 : stream_if.in_data_i;

    assign stream_if.in_ready_o  = inReady;
    assign busy_o                = (state_q != IDLE);
    assign filter_o              = filter_q;
    assign ifmap_o               = ifmap_q;
    assign read_new_filter_val_o = readFilt_q;
    assign read_new_ifmap_val_o  = readIfmap_q;
    assign start_conv_o          = startConv_q;
    assign row_done_o            = rowDone_q;

    // start_conv is raised the cycle after START so it never overlaps the last ifmap pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            tapCnt_q     <= '0;
            winCnt_q     <= '0;
            filtLoaded_q <= 1'b0;
            filter_q     <= '0;
            ifmap_q      <= '0;
            readFilt_q   <= 1'b0;
            readIfmap_q  <= 1'b0;
            startConv_q  <= 1'b0;
            rowDone_q    <= 1'b0;
        end else begin
            readFilt_q  <= 1'b0;
            readIfmap_q <= 1'b0;
            startConv_q <= 1'b0;
            rowDone_q   <= 1'b0;
            if (ifmapEmit) begin
                ifmap_q     <= ifmap_d;
                readIfmap_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cfg_load_i) begin
                        state_q  <= LOAD_FILT;
                        tapCnt_q <= '0;
                    end else if (row_start_i && filtLoaded_q) begin
                        state_q  <= PRIME;
                        tapCnt_q <= '0;
                        winCnt_q <= '0;
                    end
                end
                LOAD_FILT: begin
                    if (xfer) begin
                        filter_q   <= stream_if.in_data_i;
                        readFilt_q <= 1'b1;
                        tapCnt_q   <= tapCnt_q + TAP_ONE;
                        if (tapCnt_q == LAST_TAP) begin
                            filtLoaded_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                end
                PRIME: begin
                    if (ifmapEmit) begin
                        tapCnt_q <= tapCnt_q + TAP_ONE;
                        if (tapCnt_q == LAST_TAP) begin
                            state_q <= START;
                        end
                    end
                end
                START: begin
                    startConv_q <= 1'b1;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (psum_valid_i) begin
                        winCnt_q <= winCnt_q + WIN_ONE;
                        if (winCnt_q == LAST_WIN) begin
                            rowDone_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (ifmapEmit) begin
                        state_q <= START;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
